mat_addsub_path: RTL and testbench

Parametrised, multi-cycle matrix add/subtract datapath for the matrix calculator. It latches two N×N matrices of EW-bit elements and processes LANES element pairs per cycle. It supports addition or subtraction in unsigned or signed mode and assembles an N×N result of OUT_W-bit elements in a result register. It replaces the fixed 4×4 unsigned single-beat add path and sits beside the multiply path under the top-level controller, with the same start/finish style handshake.

---
 rtl/mat_addsub_path_if.sv | 25 ++
 rtl/mat_addsub_path.sv | 94 +++++++++
 tb/tb_mat_addsub_path.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mat_addsub_path_if.sv
// rtl/mat_addsub_path_if.sv - start/finish handshake and matrix operand/result bundle
interface mat_addsub_path_if #(
  parameter int N     = 4,
  parameter int EW    = 4,
  parameter int OUT_W = 10
) ();
  logic                   start;
  logic                   sub;
  logic                   is_signed;
  logic [N*N*EW-1:0]      mat_A;
  logic [N*N*EW-1:0]      mat_B;
  logic [N*N*OUT_W-1:0]   mat_out;
  logic                   busy;
  logic                   finish;

  modport master (
    output start, sub, is_signed, mat_A, mat_B,
    input  mat_out, busy, finish
  );

  modport slave (
    input  start, sub, is_signed, mat_A, mat_B,
    output mat_out, busy, finish
  );
endinterface

// File: rtl/mat_addsub_path.sv
// rtl/mat_addsub_path.sv - multi-beat N x N matrix add/subtract, LANES elements per cycle
module mat_addsub_path #(
  parameter int N     = 4,
  parameter int EW    = 4,
  parameter int OUT_W = 10,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mat_addsub_path_if.slave  bus
);
  localparam int ELEMS = N * N;
  localparam int BEATS = ELEMS / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nx;
  logic [ELEMS*EW-1:0]      a_q, b_q;
  logic                     sub_q, sgn_q;
  logic [CW-1:0]            cnt;
  logic [ELEMS*OUT_W-1:0]   out_q;
  logic                     busy_q, finish_q;
  logic                     load, last_beat;
  logic [OUT_W-1:0]         res [LANES];

  assign last_beat = (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin load = 1'b1; state_nx = RUN; end
      RUN:  if (last_beat) state_nx = DONE;
      DONE: if (bus.start) begin load = 1'b1; state_nx = RUN; end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are widened to EW+1 bits so the sum/difference never overflows.
  always_comb begin
    logic [EW-1:0] ea, eb;
    logic [EW:0]   xa, xb, d;
    int            idx;
    res = '{default: '0};
    for (int l = 0; l < LANES; l++) begin
      idx = int'(cnt) * LANES + l;
      ea  = a_q[(ELEMS-1-idx)*EW +: EW];
      eb  = b_q[(ELEMS-1-idx)*EW +: EW];
      xa  = {sgn_q & ea[EW-1], ea};
      xb  = {sgn_q & eb[EW-1], eb};
      d   = sub_q ? (xa - xb) : (xa + xb);
      // Unsigned subtraction can go negative, so it is sign-extended like signed mode.
      res[l] = (sgn_q | sub_q) ? OUT_W'($signed(d)) : OUT_W'(d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      sgn_q    <= 1'b0;
      cnt      <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      busy_q   <= (state_nx == RUN);
      finish_q <= (state_nx == DONE);
      if (load) begin
        a_q   <= bus.mat_A;
        b_q   <= bus.mat_B;
        sub_q <= bus.sub;
        sgn_q <= bus.is_signed;
        cnt   <= '0;
        out_q <= '0;
      end else if (state == RUN) begin
        for (int l = 0; l < LANES; l++)
          out_q[(ELEMS-1-(int'(cnt)*LANES+l))*OUT_W +: OUT_W] <= res[l];
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
    end
  end

  assign bus.mat_out = out_q;
  assign bus.busy    = busy_q;
  assign bus.finish  = finish_q;
endmodule

// File: tb/tb_mat_addsub_path.sv
// tb/tb_mat_addsub_path.sv - directed checks of mat_addsub_path plus a small parameter sweep
module tb_mat_addsub_path;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_asserts = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mat_addsub_path_if #(.N(4), .EW(4), .OUT_W(10)) d ();
  mat_addsub_path_if #(.N(4), .EW(4), .OUT_W(10)) s1 ();
  mat_addsub_path_if #(.N(4), .EW(4), .OUT_W(10)) s2 ();
  mat_addsub_path_if #(.N(3), .EW(8), .OUT_W(12)) s3 ();

  mat_addsub_path #(.N(4), .EW(4), .OUT_W(10), .LANES(4))  u_dut (.clk(clk), .rst_n(rst_n), .bus(d));
  mat_addsub_path #(.N(4), .EW(4), .OUT_W(10), .LANES(16)) u_sw1 (.clk(clk), .rst_n(rst_n), .bus(s1));
  mat_addsub_path #(.N(4), .EW(4), .OUT_W(10), .LANES(1))  u_sw2 (.clk(clk), .rst_n(rst_n), .bus(s2));
  mat_addsub_path #(.N(3), .EW(8), .OUT_W(12), .LANES(3))  u_sw3 (.clk(clk), .rst_n(rst_n), .bus(s3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] rep(logic [9:0] e);
    return {16{e}};
  endfunction

  // Integer reference: element i of each operand sits at the MSB end first.
  function automatic logic [191:0] model(int n, int ew, int ow, logic [191:0] a, logic [191:0] b,
                                         logic s, logic g);
    logic [191:0] r = '0;
    for (int i = 0; i < n*n; i++) begin
      longint av = 0, bv = 0, dv;
      for (int k = 0; k < ew; k++) begin
        av[k] = a[(n*n-1-i)*ew + k];
        bv[k] = b[(n*n-1-i)*ew + k];
      end
      if (g && av[ew-1]) av = av - (64'sd1 <<< ew);
      if (g && bv[ew-1]) bv = bv - (64'sd1 <<< ew);
      dv = s ? av - bv : av + bv;
      for (int k = 0; k < ow; k++) r[(n*n-1-i)*ow + k] = dv[k];
    end
    return r;
  endfunction

  task automatic op(logic [63:0] a, logic [63:0] b, logic s, logic g, output int lat, output int bcyc);
    d.mat_A = a; d.mat_B = b; d.sub = s; d.is_signed = g; d.start = 1'b1;
    step();
    d.start = 1'b0;
    lat = 0;
    bcyc = int'(d.busy);
    while (!d.finish && lat < 40) begin
      step();
      lat++;
      if (d.busy) bcyc++;
    end
  endtask

  initial begin
    int lat, bcyc;
    logic [191:0] exp;
    logic [191:0] sa, sb;
    logic ss, sg;

    d.start = 0; d.sub = 0; d.is_signed = 0; d.mat_A = '0; d.mat_B = '0;
    s1.start = 0; s1.sub = 0; s1.is_signed = 0; s1.mat_A = '0; s1.mat_B = '0;
    s2.start = 0; s2.sub = 0; s2.is_signed = 0; s2.mat_A = '0; s2.mat_B = '0;
    s3.start = 0; s3.sub = 0; s3.is_signed = 0; s3.mat_A = '0; s3.mat_B = '0;
    step(); step();
    chk("rst_busy", d.busy, 0);
    chk("rst_finish", d.finish, 0);
    chk("rst_out", d.mat_out, 0);
    rst_n = 1'b1;
    step();

    // 3+5 with a look at the partially written result after beat 0
    d.mat_A = {16{4'h3}}; d.mat_B = {16{4'h5}}; d.sub = 0; d.is_signed = 0; d.start = 1;
    step();
    d.start = 0;
    chk("add35_busy_k", d.busy, 1);
    chk("add35_out_k", d.mat_out, 0);
    step();
    chk("add35_beat0", d.mat_out, {{4{10'h008}}, 120'b0});
    step(); step();
    chk("add35_fin_k3", d.finish, 0);
    step();
    chk("add35_fin_k4", d.finish, 1);
    chk("add35_busy_k4", d.busy, 0);
    chk("add35_out", d.mat_out, rep(10'h008));

    op({16{4'hF}}, {16{4'hF}}, 0, 0, lat, bcyc);
    chk("uaddFF_lat", lat, 4);
    chk("uaddFF_busy", bcyc, 4);
    chk("uaddFF_out", d.mat_out, rep(10'h01E));
    op({16{4'h2}}, {16{4'h5}}, 1, 0, lat, bcyc);
    chk("usub25_out", d.mat_out, rep(10'h3FD));
    op({16{4'h0}}, {16{4'h0}}, 1, 0, lat, bcyc);
    chk("usub00_out", d.mat_out, rep(10'h000));
    op({16{4'h8}}, {16{4'h8}}, 0, 1, lat, bcyc);
    chk("sadd88_out", d.mat_out, rep(10'h3F0));
    op({16{4'h7}}, {16{4'h8}}, 1, 1, lat, bcyc);
    chk("ssub78_out", d.mat_out, rep(10'h00F));

    op(64'h0123456789ABCDEF, 64'h0, 0, 0, lat, bcyc);
    exp = '0;
    for (int i = 0; i < 16; i++) exp = (exp << 10) | 192'(i);
    chk("order_out", d.mat_out, exp);
    chk("order_msb", d.mat_out[159:150], 10'h000);
    chk("order_lsb", d.mat_out[9:0], 10'h00F);

    // start pulse and operand change during RUN are both ignored
    d.mat_A = {16{4'h1}}; d.mat_B = {16{4'h2}}; d.sub = 0; d.is_signed = 0; d.start = 1;
    step();
    d.start = 0;
    step();
    d.start = 1; d.mat_A = {16{4'h9}}; d.sub = 1;
    step();
    d.start = 0;
    lat = 2;
    while (!d.finish && lat < 40) begin step(); lat++; end
    chk("run_ign_lat", lat, 4);
    chk("run_ign_out", d.mat_out, rep(10'h003));

    // restart straight from DONE
    d.mat_A = {16{4'h4}}; d.mat_B = {16{4'h1}}; d.sub = 1; d.is_signed = 0; d.start = 1;
    step();
    d.start = 0;
    chk("redo_finish", d.finish, 0);
    chk("redo_busy", d.busy, 1);
    chk("redo_clear", d.mat_out, 0);
    lat = 0;
    while (!d.finish && lat < 40) begin step(); lat++; end
    chk("redo_lat", lat, 4);
    chk("redo_out", d.mat_out, rep(10'h003));

    // reset while beat 2 would be written
    d.mat_A = {16{4'h6}}; d.mat_B = {16{4'h6}}; d.sub = 0; d.start = 1;
    step();
    d.start = 0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("mrst_busy", d.busy, 0);
    chk("mrst_finish", d.finish, 0);
    chk("mrst_out", d.mat_out, 0);
    rst_n = 1'b1;
    step(); step();
    chk("mrst_idle_fin", d.finish, 0);
    op({16{4'hA}}, {16{4'h3}}, 1, 1, lat, bcyc);
    chk("mrst_lat", lat, 4);
    chk("mrst_out2", d.mat_out, rep(10'h3F7));

    for (int r = 0; r < 3; r++) begin
      sa = {$urandom, $urandom}; sb = {$urandom, $urandom};
      ss = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      s1.mat_A = sa[63:0]; s1.mat_B = sb[63:0]; s1.sub = ss; s1.is_signed = sg; s1.start = 1;
      step();
      s1.start = 0;
      lat = 0;
      while (!s1.finish && lat < 40) begin step(); lat++; end
      chk("sw_l16_lat", lat, 1);
      chk("sw_l16_out", s1.mat_out, model(4, 4, 10, sa, sb, ss, sg));
    end
    for (int r = 0; r < 3; r++) begin
      sa = {$urandom, $urandom}; sb = {$urandom, $urandom};
      ss = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      s2.mat_A = sa[63:0]; s2.mat_B = sb[63:0]; s2.sub = ss; s2.is_signed = sg; s2.start = 1;
      step();
      s2.start = 0;
      lat = 0;
      while (!s2.finish && lat < 40) begin step(); lat++; end
      chk("sw_l1_lat", lat, 16);
      chk("sw_l1_out", s2.mat_out, model(4, 4, 10, sa, sb, ss, sg));
    end
    for (int r = 0; r < 3; r++) begin
      sa = {$urandom, $urandom, $urandom}; sb = {$urandom, $urandom, $urandom};
      sa[191:72] = '0; sb[191:72] = '0;
      ss = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      s3.mat_A = sa[71:0]; s3.mat_B = sb[71:0]; s3.sub = ss; s3.is_signed = sg; s3.start = 1;
      step();
      s3.start = 0;
      lat = 0;
      while (!s3.finish && lat < 40) begin step(); lat++; end
      chk("sw_n3_lat", lat, 3);
      chk("sw_n3_out", s3.mat_out, model(3, 8, 12, sa, sb, ss, sg));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
